// File: rtl/rs232_pkg.sv
// rs232_pkg: shared constants and state types for the RS-232 packet transmitter.
//   SOF_DEFAULT / EOF_DEFAULT : default framing bytes of the 8-byte packet
//   PKT_BYTES                 : bytes per packet (SOF, six payload bytes, EOF)
//   tx_state_e                : per-byte serial states (IDLE, START, DATA, PARITY, STOP, GAP)
//   pkt_state_e               : packet-level sequencing states (IDLE, SEND, DONE)
// Optional feature macro: TX_PARITY_EN (PARITY state is only entered when defined).
package rs232_pkg;

  localparam logic [7:0]  SOF_DEFAULT = 8'h02;
  localparam logic [7:0]  EOF_DEFAULT = 8'h03;
  localparam int unsigned PKT_BYTES   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } tx_state_e;

  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_SEND,
    PKT_DONE
  } pkt_state_e;

endpackage

// File: rtl/rs232_byte_tx.sv
// rs232_byte_tx: serialises one byte, LSB first: start, 8 data, [parity], stop, gap.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   byte_go    : load byte_in and begin its start bit on this edge
//   byte_in    : byte to send
//   byte_done  : high in the last cycle of the byte (last stop/gap bit time)
//   tx         : registered serial line, idle high
// Macro TX_PARITY_EN adds an even-parity bit after data bit 7.
module rs232_byte_tx
  import rs232_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 40,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_go,
  input  logic [7:0] byte_in,
  output logic       byte_done,
  output logic       tx
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    gap_q, gap_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
`ifdef TX_PARITY_EN
  logic          par_q, par_d;
`endif
  logic          wrap;

  assign wrap = (cnt_q == CNT_LAST);
  assign tx   = tx_q;

  always_comb begin
    byte_done = 1'b0;
    if (wrap) begin
      if (state_q == ST_STOP && GAP_BITS == 0) byte_done = 1'b1;
      if (state_q == ST_GAP && gap_q == GAP_LAST) byte_done = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
`ifdef TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != ST_IDLE) cnt_d = wrap ? '0 : cnt_q + CW'(1);
    if (wrap) begin
      unique case (state_q)
        ST_START: begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
        ST_DATA: begin
          if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
        ST_PARITY: begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
        ST_STOP: begin
          if (GAP_BITS != 0) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) state_d = ST_IDLE;
          else                   gap_d   = gap_q + 4'd1;
        end
        default: ;
      endcase
    end
    // A new byte may be launched on the same edge the previous one ends,
    // so the next start bit follows the last stop/gap bit with no idle cycle.
    if (byte_go) begin
      state_d = ST_START;
      cnt_d   = '0;
      shreg_d = byte_in;
      tx_d    = 1'b0;
`ifdef TX_PARITY_EN
      par_d   = ^byte_in;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: rtl/rs232_packet_tx.sv
// rs232_packet_tx: sends one 8-byte packet {EOF, payload[47:0], SOF} over RS-232.
// Ports:
//   clk       : clock, all logic on posedge
//   rst       : asynchronous active-high reset; aborts any packet in flight
//   tx_start  : request to send, sampled only while idle
//   payload   : bytes 1..6 (payload[7:0] is byte 1), latched on accept
//   data_out  : registered serial line, idle high
//   busy      : high from accept until the end of the last gap
//   done      : one-cycle pulse after the last byte
// Macro TX_PARITY_EN: each byte carries an even-parity bit before its stop bit.
module rs232_packet_tx
  import rs232_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 40,
  parameter int unsigned GAP_BITS     = 1,
  parameter logic [7:0]  SOF_BYTE     = SOF_DEFAULT,
  parameter logic [7:0]  EOF_BYTE     = EOF_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [47:0] payload,
  output logic        data_out,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDX_LAST = 3'(PKT_BYTES - 1);

  pkt_state_e  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [63:0] frame_q, frame_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        byte_go;
  logic        byte_done;
  logic [7:0]  byte_sel;
  logic [2:0]  idx_next;

  assign idx_next = idx_q + 3'd1;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    byte_go  = 1'b0;
    byte_sel = SOF_BYTE;
    unique case (state_q)
      PKT_IDLE: begin
        if (tx_start) begin
          frame_d  = {EOF_BYTE, payload, SOF_BYTE};
          idx_d    = '0;
          busy_d   = 1'b1;
          byte_go  = 1'b1;
          byte_sel = SOF_BYTE;
          state_d  = PKT_SEND;
        end
      end
      PKT_SEND: begin
        if (byte_done) begin
          // Finishing byte 7 ends the packet; the index never wraps to 0.
          if (idx_q == IDX_LAST) begin
            state_d = PKT_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d    = idx_next;
            byte_go  = 1'b1;
            byte_sel = frame_q[{idx_next, 3'b000} +: 8];
          end
        end
      end
      PKT_DONE: state_d = PKT_IDLE;
      default:  state_d = PKT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PKT_IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  rs232_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .GAP_BITS     (GAP_BITS)
  ) u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .byte_go   (byte_go),
    .byte_in   (byte_sel),
    .byte_done (byte_done),
    .tx        (data_out)
  );

endmodule

// File: tb/tb_rs232_packet_tx.sv
module tb_rs232_packet_tx;

`ifdef TX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [47:0] payload = '0;
  logic        out0, busy0, done0;
  logic        out1, busy1, done1;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  rs232_packet_tx dut0 (
    .clk      (clk),
    .rst      (rst),
    .tx_start (start0),
    .payload  (payload),
    .data_out (out0),
    .busy     (busy0),
    .done     (done0)
  );

  rs232_packet_tx #(
    .CLKS_PER_BIT (2),
    .GAP_BITS     (0)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .tx_start (start1),
    .payload  (payload),
    .data_out (out1),
    .busy     (busy1),
    .done     (done1)
  );

  function automatic logic line_of(input int sel);
    return (sel == 1) ? out1 : out0;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 1) ? busy1 : busy0;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 1) ? done1 : done0;
  endfunction

  // Drives a one-cycle tx_start; returns at the negedge just after the accept edge (t=0).
  task automatic start_packet(input int sel, input logic [47:0] pl, input bit expect_it);
    @(negedge clk);
    payload = pl;
    if (sel == 1) start1 = 1'b1;
    else          start0 = 1'b1;
    if (expect_it) begin
      sb_q.push_back(8'h02);
      for (int i = 0; i < 6; i++) sb_q.push_back(pl[8*i +: 8]);
      sb_q.push_back(8'h03);
    end
    @(negedge clk);
    start0  = 1'b0;
    start1  = 1'b0;
    payload = ~pl;
  endtask

  // Samples every cycle from t=0 to t=L+1, decoding 8 bytes against the scoreboard.
  task automatic check_packet(input int sel, input int cpb, input int gap, input string tag);
    int          fb, len;
    bit          unstable, bad_busy;
    logic        v0;
    logic [31:0] slots, exp_slots, mask;
    logic [7:0]  exp_b, got_b;
    fb       = 10 + PBIT + gap;
    len      = 8 * fb * cpb;
    mask     = (32'h1 << fb) - 32'h1;
    bad_busy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      unstable = 1'b0;
      slots    = '0;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard empty at byte %0d", tag, k);
        exp_b = '0;
      end else begin
        exp_b = sb_q.pop_front();
      end
      for (int s = 0; s < fb; s++) begin
        v0 = line_of(sel);
        for (int c = 0; c < cpb; c++) begin
          if (line_of(sel) !== v0) unstable = 1'b1;
          if (busy_of(sel) !== 1'b1 || done_of(sel) !== 1'b0) bad_busy = 1'b1;
          @(negedge clk);
        end
        slots[s] = v0;
      end
      got_b        = slots[8:1];
      exp_slots    = '1;
      exp_slots[0] = 1'b0;
      exp_slots[8:1] = exp_b;
      if (PBIT == 1) exp_slots[9] = ^exp_b;
      checks++;
      if (got_b !== exp_b) begin
        errors++;
        $display("FAIL %s byte%0d data got %h want %h", tag, k, got_b, exp_b);
      end
      checks++;
      if ((slots & mask) !== (exp_slots & mask)) begin
        errors++;
        $display("FAIL %s byte%0d frame got %h want %h", tag, k, slots & mask, exp_slots & mask);
      end
      checks++;
      if (unstable !== 1'b0) begin
        errors++;
        $display("FAIL %s byte%0d bit_timing got unstable=%0b want 0", tag, k, unstable);
      end
`ifdef TX_PARITY_EN
      checks++;
      if (slots[9] !== ^exp_b) begin
        errors++;
        $display("FAIL %s byte%0d parity got %0b want %0b", tag, k, slots[9], ^exp_b);
      end
`endif
    end
    checks++;
    if (bad_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_during got bad=%0b want busy=1 done=0 for %0d cycles", tag, bad_busy, len);
    end
    checks++;
    if ({done_of(sel), busy_of(sel), line_of(sel)} !== 3'b101) begin
      errors++;
      $display("FAIL %s done_at_L=%0d got done,busy,line=%b want 101", tag, len,
               {done_of(sel), busy_of(sel), line_of(sel)});
    end
    @(negedge clk);
    checks++;
    if ({done_of(sel), busy_of(sel)} !== 2'b00) begin
      errors++;
      $display("FAIL %s after_done got done,busy=%b want 00", tag, {done_of(sel), busy_of(sel)});
    end
  endtask

  // Checks dut0 stays idle (line high, not busy, no done) for n cycles.
  task automatic check_idle(input int n, input string tag);
    bit   bad;
    logic [2:0] seen;
    bad  = 1'b0;
    seen = 3'b100;
    for (int i = 0; i < n; i++) begin
      if ({out0, busy0, done0} !== 3'b100 && !bad) begin
        bad  = 1'b1;
        seen = {out0, busy0, done0};
      end
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s got line,busy,done=%b want 100", tag, seen);
    end
  endtask

  task automatic test_reset();
    bit   bad;
    logic [2:0] seen;
    rst  = 1'b1;
    bad  = 1'b0;
    seen = 3'b100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({out0, busy0, done0} !== 3'b100 && !bad) begin
        bad  = 1'b1;
        seen = {out0, busy0, done0};
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_state got line,busy,done=%b want 100", seen);
    end
    rst = 1'b0;
    check_idle(200, "reset_idle");
    checks++;
    if ({out1, busy1, done1} !== 3'b100) begin
      errors++;
      $display("FAIL reset_idle_dut1 got line,busy,done=%b want 100", {out1, busy1, done1});
    end
  endtask

  task automatic test_single();
    start_packet(0, 48'h1234_5678_9A85, 1'b1);
    check_packet(0, 40, 1, "single");
  endtask

  task automatic test_ignore_busy();
    int len;
    len = 8 * (10 + PBIT + 1) * 40;
    start_packet(0, 48'hCAFE_F00D_1357, 1'b1);
    fork
      check_packet(0, 40, 1, "ignore");
      begin
        repeat (99) @(negedge clk);
        start0  = 1'b1;
        payload = 48'hDEAD_BEEF_0000;
        @(negedge clk);
        start0  = 1'b0;
        repeat (len - 1 - 100) @(negedge clk);
        start0  = 1'b1;
        payload = 48'h5555_AAAA_FFFF;
        repeat (2) @(negedge clk);
        start0  = 1'b0;
      end
    join
    check_idle(150, "ignore_no_second");
  endtask

  task automatic test_abort();
    bit   bad;
    logic [2:0] seen;
    start_packet(0, 48'h0F1E_2D3C_4B5A, 1'b0);
    repeat (999) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({out0, busy0, done0} !== 3'b100) begin
      errors++;
      $display("FAIL abort_immediate got line,busy,done=%b want 100", {out0, busy0, done0});
    end
    bad  = 1'b0;
    seen = 3'b100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({out0, busy0, done0} !== 3'b100 && !bad) begin
        bad  = 1'b1;
        seen = {out0, busy0, done0};
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_during_rst got line,busy,done=%b want 100", seen);
    end
    rst = 1'b0;
    check_idle(200, "abort_no_done");
    start_packet(0, 48'h0, 1'b1);
    check_packet(0, 40, 1, "after_abort");
  endtask

  task automatic test_gap0();
    start_packet(1, 48'hA53C_0FF0_817E, 1'b1);
    check_packet(1, 2, 0, "gap0");
  endtask

  task automatic test_parity();
    start_packet(0, 48'h0000_0000_0007, 1'b1);
    check_packet(0, 40, 1, "parity");
  endtask

  task automatic test_back_to_back();
    start_packet(0, 48'h0102_0304_0506, 1'b1);
    check_packet(0, 40, 1, "b2b_first");
    // check_packet returns in the first idle cycle; accept the next packet right away.
    payload = 48'hF0E1_D2C3_B4A5;
    start0  = 1'b1;
    sb_q.push_back(8'h02);
    for (int i = 0; i < 6; i++) sb_q.push_back(payload[8*i +: 8]);
    sb_q.push_back(8'h03);
    @(negedge clk);
    start0 = 1'b0;
    check_packet(0, 40, 1, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignore_busy();
    test_abort();
    test_gap0();
    test_parity();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
